// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer
// Control FSM for the 3x3 row-stationary convolution datapath. A single
// start pulse walks NUM_ROWS IFM rows of IFM_W pixels each. For every
// loaded pixel it generates the weight/IFM load strobes, the per-row psum
// FIFO read/write enables and the pointer-clear pulses. It optionally ends
// the layer with an output drain from FIFO 2.
//
// Optional feature macro: ROW_SEQ_DRAIN_EN
//   defined   : DRAIN state of OFM_SIZE cycles follows the last row's GAP
//   undefined : last row's GAP goes straight to DONE (no drain)
//
// Ports
//   clk1                 in   only clock, rising edge
//   rst                  in   asynchronous, active-high reset
//   start                in   one-cycle layer start, honoured only in IDLE
//   ifm_valid            in   pixel present; low stalls LOAD (Mealy gate)
//   set_wgt, set_ifm     out  weight / IFM register load strobes
//   start_conv           out  first pixel of the layer
//   wr_en_0..2           out  psum FIFO write enables
//   rd_en_0..2           out  psum FIFO read enables
//   wr_clr, rd_clr       out  FIFO write / read pointer clears
//   row_idx, col_idx     out  current row / column
//   busy                 out  high outside IDLE
//   done                 out  one-cycle layer-complete pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | streaming pixels of row r, column c advances on ifm_valid
// GAP   | one bubble cycle between rows, all strobes low
// DRAIN | OFM_SIZE cycles reading FIFO 2 (ROW_SEQ_DRAIN_EN only)
// DONE  | one-cycle done pulse, then back to IDLE
module conv_row_sequencer #(
  parameter int IFM_W       = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_ROWS    = 7,
  parameter int OFM_SIZE    = 7
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        ifm_valid,
  output logic                        set_wgt,
  output logic                        set_ifm,
  output logic                        start_conv,
  output logic                        wr_en_0,
  output logic                        wr_en_1,
  output logic                        wr_en_2,
  output logic                        rd_en_0,
  output logic                        rd_en_1,
  output logic                        rd_en_2,
  output logic                        wr_clr,
  output logic                        rd_clr,
  output logic [$clog2(NUM_ROWS)-1:0] row_idx,
  output logic [$clog2(IFM_W)-1:0]    col_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(IFM_W);
  localparam logic [RW-1:0] R_LAST = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IFM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [2:0]    wr_mask, rd_mask;

`ifdef ROW_SEQ_DRAIN_EN
  localparam int DW = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(OFM_SIZE - 1);
  logic [DW-1:0] d_q, d_d;
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
`ifdef ROW_SEQ_DRAIN_EN
      d_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
`ifdef ROW_SEQ_DRAIN_EN
      d_q     <= d_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
`ifdef ROW_SEQ_DRAIN_EN
    d_d        = d_q;
`endif
    set_wgt    = 1'b0;
    set_ifm    = 1'b0;
    start_conv = 1'b0;
    wr_clr     = 1'b0;
    rd_clr     = 1'b0;
    done       = 1'b0;
    {wr_en_2, wr_en_1, wr_en_0} = 3'b000;
    {rd_en_2, rd_en_1, rd_en_0} = 3'b000;

    // Row r writes FIFOs 0..min(r,2) and reads FIFOs below min(r,3):
    // each FIFO is read back by the row after the one that filled it.
    for (int k = 0; k < 3; k++) begin
      wr_mask[k] = (int'(r_q) >= k);
      rd_mask[k] = (int'(r_q) > k);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_LOAD: begin
        if (ifm_valid) begin
          set_wgt    = 1'b1;
          set_ifm    = 1'b1;
          start_conv = (r_q == '0) && (c_q == '0);
          wr_clr     = (r_q != '0) && (c_q == '0);
          rd_clr     = (r_q != '0) && (int'(c_q) == IFM_W - 2);
          if (int'(c_q) >= KERNEL_SIZE) {wr_en_2, wr_en_1, wr_en_0} = wr_mask;
          if (int'(c_q) <= IFM_W - 3)   {rd_en_2, rd_en_1, rd_en_0} = rd_mask;
          if (c_q == C_LAST) state_d = S_GAP;
          else               c_d     = c_q + CW'(1);
        end
      end
      S_GAP: begin
        if (r_q != R_LAST) begin
          state_d = S_LOAD;
          r_d     = r_q + RW'(1);
          c_d     = '0;
        end else begin
`ifdef ROW_SEQ_DRAIN_EN
          state_d = S_DRAIN;
          d_d     = '0;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ROW_SEQ_DRAIN_EN
      S_DRAIN: begin
        wr_clr  = (d_q == '0);
        rd_en_2 = 1'b1;
        if (d_q == D_LAST) state_d = S_DONE;
        else               d_d     = d_q + DW'(1);
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        r_d     = '0;
        c_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign row_idx = r_q;
  assign col_idx = c_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
module tb_conv_row_sequencer;

  localparam int NR  = 7;
  localparam int W   = 9;
  localparam int K   = 3;
  localparam int OFM = 7;
`ifdef ROW_SEQ_DRAIN_EN
  localparam int DRAIN_N = OFM;
`else
  localparam int DRAIN_N = 0;
`endif

  logic       clk1 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ifm_valid = 1'b0;
  logic       set_wgt, set_ifm, start_conv;
  logic       wr_en_0, wr_en_1, wr_en_2;
  logic       rd_en_0, rd_en_1, rd_en_2;
  logic       wr_clr, rd_clr, busy, done;
  logic [2:0] row_idx;
  logic [3:0] col_idx;

  conv_row_sequencer #(
    .IFM_W(W), .KERNEL_SIZE(K), .NUM_ROWS(NR), .OFM_SIZE(OFM)
  ) dut (
    .clk1(clk1), .rst(rst), .start(start), .ifm_valid(ifm_valid),
    .set_wgt(set_wgt), .set_ifm(set_ifm), .start_conv(start_conv),
    .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
    .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
    .wr_clr(wr_clr), .rd_clr(rd_clr), .row_idx(row_idx), .col_idx(col_idx),
    .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  // Vector layout: {set_wgt,set_ifm,start_conv,wr_en[2:0],rd_en[2:0],
  //                 wr_clr,rd_clr,done,row[2:0],col[3:0]}
  logic [18:0] exp_q[$];
  int          exp_busy_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_stall = 1'b0;
  logic [2:0]  chk_row = '0;
  logic [3:0]  chk_col = '0;
  logic        fin = 1'b0;

  function automatic logic [18:0] mk(input logic sw, input logic si, input logic sc,
                                     input logic [2:0] we, input logic [2:0] re,
                                     input logic wc, input logic rc, input logic dn,
                                     input int r, input int c);
    return {sw, si, sc, we, re, wc, rc, dn, 3'(r), 4'(c)};
  endfunction

  // Reference model: the ordered list of every non-idle output cycle of one
  // layer. Stalls and GAP cycles emit nothing, so the list is stall-independent.
  function automatic void push_layer();
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < W; c++) begin
        int wl = (r < 2) ? r : 2;
        int rl = (r < 3) ? r : 3;
        logic [2:0] we = 3'b000;
        logic [2:0] re = 3'b000;
        for (int k = 0; k < 3; k++) begin
          if (c >= K && k <= wl) we[k] = 1'b1;
          if (c <= W - 3 && k < rl) re[k] = 1'b1;
        end
        exp_q.push_back(mk(1'b1, 1'b1, (r == 0 && c == 0), we, re,
                           (r > 0 && c == 0), (r > 0 && c == W - 2), 1'b0, r, c));
      end
    end
    for (int d = 0; d < DRAIN_N; d++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b100, (d == 0), 1'b0, 1'b0, NR - 1, W - 1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, NR - 1, W - 1));
  endfunction

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // mode 0: no stalls, 1: random stalls, 2: 4-cycle stall at row2 c5,
  // 3: start pulse during row4, 4: reset at row5 c4
  task automatic run_layer(input int mode);
    int stalls = 0;
    int nst;
    push_layer();
    start     = 1'b1;
    ifm_valid = 1'($urandom);
    step();
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < W; c++) begin
        start = 1'b0;
        if (mode == 4 && r == 5 && c == 4) begin
          rst       = 1'b1;
          ifm_valid = 1'b1;
          step();
          step();
          exp_q.delete();
          rst = 1'b0;
          return;
        end
        nst = 0;
        if (mode == 1 && $urandom_range(0, 3) == 0) nst = int'($urandom_range(1, 3));
        if (mode == 2 && r == 2 && c == 5) nst = 4;
        repeat (nst) begin
          ifm_valid = 1'b0;
          chk_stall = 1'b1;
          chk_row   = 3'(r);
          chk_col   = 4'(c);
          stalls++;
          step();
        end
        chk_stall = 1'b0;
        ifm_valid = 1'b1;
        if (mode == 3 && r == 4 && c == 2) start = 1'b1;
        step();
      end
      start     = 1'b0;
      ifm_valid = 1'($urandom);
      step();
    end
    exp_busy_q.push_back(NR * (W + 1) + DRAIN_N + 1 + stalls);
    for (int d = 0; d <= DRAIN_N; d++) begin
      ifm_valid = 1'($urandom);
      step();
    end
    ifm_valid = 1'b0;
    step();
  endtask

  logic [18:0] obs, e;
  int          busy_run = 0;
  int          eb;

  always @(negedge clk1) begin
    obs = {set_wgt, set_ifm, start_conv, wr_en_2, wr_en_1, wr_en_0,
           rd_en_2, rd_en_1, rd_en_0, wr_clr, rd_clr, done, row_idx, col_idx};
    if (rst) begin
      n_vec++;
      if ({obs, busy} != 20'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got %h busy=%b, want all zero", obs, busy);
      end
      busy_run = 0;
    end else begin
      if (obs[18:7] != 12'd0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe: got %h, no output expected", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs != e) begin
            n_err++;
            $display("FAIL strobe_seq: got %h, want %h", obs, e);
          end
        end
      end
      if (chk_stall) begin
        n_vec++;
        if (obs != {12'd0, chk_row, chk_col} || !busy) begin
          n_err++;
          $display("FAIL stall_hold: got %h busy=%b, want %h busy=1",
                   obs, busy, {12'd0, chk_row, chk_col});
        end
      end
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        n_vec++;
        if (exp_busy_q.size() == 0) begin
          n_err++;
          $display("FAIL busy_len: got %0d cycles, none expected", busy_run);
        end else begin
          eb = exp_busy_q.pop_front();
          if (busy_run != eb) begin
            n_err++;
            $display("FAIL busy_len: got %0d cycles, want %0d", busy_run, eb);
          end
        end
        busy_run = 0;
      end
    end
    if (fin) begin
      n_vec++;
      if (exp_q.size() != 0 || exp_busy_q.size() != 0 || busy) begin
        n_err++;
        $display("FAIL leftover: got %0d events %0d lengths pending busy=%b, want 0 0 0",
                 exp_q.size(), exp_busy_q.size(), busy);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    run_layer(0);
    run_layer(2);
    run_layer(1);
    run_layer(1);
    run_layer(3);
    run_layer(4);
    step();
    run_layer(0);
    repeat (3) step();
    fin = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule

// File: doc/conv_row_sequencer.md
# conv_row_sequencer

Control FSM that sequences the 3x3 row-stationary convolution datapath. It replaces hand-driven enables with one `start` pulse. For every IFM row it generates the weight/IFM load strobes, the per-row psum FIFO read/write enables and clear pulses, and a final output drain. It sits between the layer controller and the TOP conv accelerator, and drives its `set_wgt`, `set_ifm`, `wr_en_*`, `rd_en_*`, `rd_clr`, `wr_clr` and `start_conv` pins directly.

## Interface
Parameters:
- `IFM_W`, 9: IFM row length in pixels (columns per row).
- `KERNEL_SIZE`, 3: kernel width; also the number of psum FIFOs (0..2).
- `NUM_ROWS`, 7: IFM rows streamed per layer.
- `OFM_SIZE`, 7: output values drained from FIFO 2 at the end.

Ports (single clock `clk1`; asynchronous, active-high reset `rst`):
- `clk1`, in, 1: the block's only clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a layer; ignored unless IDLE.
- `ifm_valid`, in, 1: the IFM source presents a pixel this cycle; low stalls LOAD.
- `set_wgt`, `set_ifm`, out, 1 each: weight/IFM register load strobes.
- `start_conv`, out, 1: pulse on the first loaded pixel of the layer.
- `wr_en_0`, `wr_en_1`, `wr_en_2`, out, 1 each: psum FIFO write enables.
- `rd_en_0`, `rd_en_1`, `rd_en_2`, out, 1 each: psum FIFO read enables.
- `wr_clr`, `rd_clr`, out, 1 each: FIFO write/read pointer clear pulses.
- `row_idx`, out, clog2(NUM_ROWS): current row.
- `col_idx`, out, clog2(IFM_W): current column.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when the layer completes.

## Operation
- States: IDLE, LOAD, GAP, DRAIN, DONE.
- Transitions:
  - IDLE→LOAD on `start`, with r=0, c=0.
  - LOAD→GAP when c=IFM_W-1 with `ifm_valid`.
  - GAP→LOAD when r<NUM_ROWS-1 (r increments, c=0); otherwise GAP→DRAIN.
  - DRAIN→DONE after OFM_SIZE cycles; DONE→IDLE unconditionally.
- FIFO masks for row r:
  - Write mask: FIFO k with k≤min(r,2).
  - Read mask: FIFO k with k<min(r,3) (row0: none; row1: FIFO0; row2: FIFOs 0,1; row≥3: all).
- LOAD outputs, all gated by `ifm_valid`; with `ifm_valid`=0 every output is 0 and c holds:
  - `set_wgt`=`set_ifm`=1.
  - `start_conv`=1 at r=0,c=0.
  - `wr_clr`=1 at r>0,c=0.
  - `wr_en_k`=1 for masked k when c≥KERNEL_SIZE.
  - `rd_en_k`=1 for masked k when c≤IFM_W-3.
  - `rd_clr`=1 at c=IFM_W-2, only when r>0.
- GAP: all strobes 0 (one bubble row separator).
- DRAIN: `wr_clr`=1 on the first DRAIN cycle; `rd_en_2`=1 for all OFM_SIZE cycles.
- DONE: `done`=1 and `busy`=1 for one cycle.
- Counters: c wraps IFM_W-1→0 only on GAP→LOAD. The drain counter is separate and saturates at OFM_SIZE-1.
- `start` while busy: ignored, with no restart or queueing.
- `rst` mid-layer: immediate return to IDLE with all outputs 0. Downstream FIFO contents are not cleared by this block.

## Timing
- Reset values: all outputs 0, state IDLE, r=c=0.
- Latency: `start` sampled at edge N; LOAD c=0 strobes appear in cycle N+1.
- State outputs are Moore, decoded from registered state and counters. `ifm_valid` gating is combinational (Mealy) in LOAD only.
- Without stalls, `busy` lasts NUM_ROWS·(IFM_W+1)+OFM_SIZE+1 = 78 cycles for the defaults; `done` appears in the last of them.
- Stall cycles extend LOAD one-for-one; no strobe is skipped or duplicated.

## Configuration
- `ROW_SEQ_DRAIN_EN` defined: DRAIN state present as above.
- Undefined: GAP of the last row goes directly to DONE; `rd_en_2` is never asserted after the last row. The no-stall busy length is 71 cycles.

## Test plan
- Reset, then `start` with `ifm_valid`=1: row0 shows `start_conv` at c=0, `wr_en_0` over c=3..8, no `rd_en_*`; `done` arrives 78 cycles after `start`.
- Row3 check: `wr_clr` at c=0; `rd_en_0/1/2` over c=0..6; `rd_clr` at c=7; `wr_en_0/1/2` over c=3..8.
- `ifm_valid` low for 4 cycles at row2 c=5: all strobes 0 and `col_idx` holds at 5; total busy becomes 82.
- `start` pulsed during row4: no effect, and the sequence and counts are unchanged.
- `rst` asserted at row5 c=4: outputs 0 within the same cycle and state IDLE; a new `start` restarts at row0.
- With `ROW_SEQ_DRAIN_EN`: 7 consecutive `rd_en_2` cycles after the last GAP, `wr_clr` on the first; without the macro, `done` 71 cycles after `start`.
